// File: rtl/commit_trace_buffer.sv
// commit_trace_buffer
//   Retire-stage trace unit. Classifies each committed instruction, numbers it,
//   counts cycles and queues fixed-format trace records in a DEPTH-entry FIFO
//   that the consumer drains over a valid/ready port. After a halt commits the
//   unit stops accepting commits, drains the FIFO and then raises a sticky done.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   cm_*                     commit interface from the retire stage
//   rec_valid / rec_ready    FIFO head handshake (pop on valid & ready)
//   rec_kind .. rec_mdata    head record fields (0 NOP,1 REG,2 LD,3 ST,4 STU,5 HALT)
//   cycle_count, inst_count  free-running cycle and committed-instruction counters
//   dropped, overflow        records lost to a full FIFO, sticky loss flag
//   done                     sticky: halt recorded and FIFO drained
module commit_trace_buffer #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned REG_W     = 3,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned CNT_W     = 32,
  parameter bit          TRACE_NOP = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cm_valid,
  input  logic [DATA_W-1:0] cm_pc,
  input  logic              cm_reg_write,
  input  logic [REG_W-1:0]  cm_write_reg,
  input  logic [DATA_W-1:0] cm_write_data,
  input  logic              cm_mem_read,
  input  logic              cm_mem_write,
  input  logic [DATA_W-1:0] cm_mem_addr,
  input  logic [DATA_W-1:0] cm_mem_data,
  input  logic              cm_halt,
  output logic              rec_valid,
  input  logic              rec_ready,
  output logic [2:0]        rec_kind,
  output logic [CNT_W-1:0]  rec_inum,
  output logic [DATA_W-1:0] rec_pc,
  output logic [DATA_W-1:0] rec_wdata,
  output logic [DATA_W-1:0] rec_addr,
  output logic [DATA_W-1:0] rec_mdata,
  output logic [REG_W-1:0]  rec_reg,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  inst_count,
  output logic [CNT_W-1:0]  dropped,
  output logic              overflow,
  output logic              done
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {RUN, DRAIN, FINISHED} stateT;
  typedef enum logic [2:0] {
    KIND_NOP  = 3'd0,
    KIND_REG  = 3'd1,
    KIND_LD   = 3'd2,
    KIND_ST   = 3'd3,
    KIND_STU  = 3'd4,
    KIND_HALT = 3'd5
  } kindT;

  typedef struct packed {
    logic [2:0]        kind;
    logic [CNT_W-1:0]  inum;
    logic [DATA_W-1:0] pc;
    logic [REG_W-1:0]  regNum;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] mdata;
  } recT;

  stateT            state;
  recT              mem [DEPTH];
  recT              newRec;
  recT              head;
  logic [AW-1:0]    wrPtr, rdPtr;
  logic [AW:0]      count;
  logic [CNT_W-1:0] cycleCount, instCount, dropCount;
  logic             overflowQ, doneQ;
  logic             accept, pushReq, push, pop, full, drop;

  // Classification in priority order; fields a kind does not use stay zero.
  always_comb begin
    newRec      = '0;
    newRec.inum = instCount;
    newRec.pc   = cm_pc;
    if (cm_halt) begin
      newRec.kind = KIND_HALT;
    end else if (cm_reg_write && cm_mem_write) begin
      newRec.kind   = KIND_STU;
      newRec.regNum = cm_write_reg;
      newRec.wdata  = cm_write_data;
      newRec.addr   = cm_mem_addr;
      newRec.mdata  = cm_mem_data;
    end else if (cm_mem_write) begin
      newRec.kind  = KIND_ST;
      newRec.addr  = cm_mem_addr;
      newRec.mdata = cm_mem_data;
    end else if (cm_reg_write && cm_mem_read) begin
      newRec.kind   = KIND_LD;
      newRec.regNum = cm_write_reg;
      newRec.wdata  = cm_write_data;
      newRec.addr   = cm_mem_addr;
    end else if (cm_reg_write) begin
      newRec.kind   = KIND_REG;
      newRec.regNum = cm_write_reg;
      newRec.wdata  = cm_write_data;
    end else begin
      newRec.kind = KIND_NOP;
    end
  end

  assign accept  = (state == RUN) && cm_valid;
  assign pushReq = accept && (TRACE_NOP || (newRec.kind != KIND_NOP));
  assign full    = (count == FULL_COUNT);
  assign pop     = rec_valid && rec_ready;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push    = pushReq && (!full || pop);
  assign drop    = pushReq && full && !pop;

  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= newRec;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      wrPtr      <= '0;
      rdPtr      <= '0;
      count      <= '0;
      cycleCount <= '0;
      instCount  <= '0;
      dropCount  <= '0;
      overflowQ  <= 1'b0;
      doneQ      <= 1'b0;
    end else begin
      cycleCount <= cycleCount + 1'b1;
      if (accept) instCount <= instCount + 1'b1;
      if (push)   wrPtr <= wrPtr + 1'b1;
      if (pop)    rdPtr <= rdPtr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop) begin
        dropCount <= dropCount + 1'b1;
        overflowQ <= 1'b1;
      end
      case (state)
        RUN: begin
          // Halt leaves RUN even if its own record was dropped.
          if (accept && cm_halt) state <= DRAIN;
        end
        DRAIN: begin
          if (count == '0) begin
            state <= FINISHED;
            doneQ <= 1'b1;
          end
        end
        default: begin
          state <= FINISHED;
          doneQ <= 1'b1;
        end
      endcase
    end
  end

  assign head        = mem[rdPtr];
  assign rec_valid   = (count != '0);
  assign rec_kind    = head.kind;
  assign rec_inum    = head.inum;
  assign rec_pc      = head.pc;
  assign rec_reg     = head.regNum;
  assign rec_wdata   = head.wdata;
  assign rec_addr    = head.addr;
  assign rec_mdata   = head.mdata;
  assign cycle_count = cycleCount;
  assign inst_count  = instCount;
  assign dropped     = dropCount;
  assign overflow    = overflowQ;
  assign done        = doneQ;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed bench for commit_trace_buffer. A second instance with TRACE_NOP=0
// shares every input with the main instance.
module tb_commit_trace_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmValid = 1'b0;
  logic [15:0] cmPc = '0;
  logic        cmRegWrite = 1'b0;
  logic [2:0]  cmWriteReg = '0;
  logic [15:0] cmWriteData = '0;
  logic        cmMemRead = 1'b0;
  logic        cmMemWrite = 1'b0;
  logic [15:0] cmMemAddr = '0;
  logic [15:0] cmMemData = '0;
  logic        cmHalt = 1'b0;
  logic        recReady = 1'b0;

  logic        recValid, recValidN;
  logic [2:0]  recKind, recKindN;
  logic [31:0] recInum, recInumN;
  logic [15:0] recPc, recPcN, recWdata, recWdataN, recAddr, recAddrN, recMdata, recMdataN;
  logic [2:0]  recReg, recRegN;
  logic [31:0] cycleCount, cycleCountN, instCount, instCountN, dropped, droppedN;
  logic        overflow, overflowN, done, doneN;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [31:0] c0;

  int unsigned haltExpInum [5] = '{0, 1, 1, 2, 3};
  logic        haltReady   [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

  always #5 clk = ~clk;

  commit_trace_buffer #(.DATA_W(16), .REG_W(3), .DEPTH(8), .CNT_W(32), .TRACE_NOP(1'b1)) dut (
    .clk(clk), .rst(rst), .cm_valid(cmValid), .cm_pc(cmPc), .cm_reg_write(cmRegWrite),
    .cm_write_reg(cmWriteReg), .cm_write_data(cmWriteData), .cm_mem_read(cmMemRead),
    .cm_mem_write(cmMemWrite), .cm_mem_addr(cmMemAddr), .cm_mem_data(cmMemData),
    .cm_halt(cmHalt), .rec_valid(recValid), .rec_ready(recReady), .rec_kind(recKind),
    .rec_inum(recInum), .rec_pc(recPc), .rec_wdata(recWdata), .rec_addr(recAddr),
    .rec_mdata(recMdata), .rec_reg(recReg), .cycle_count(cycleCount),
    .inst_count(instCount), .dropped(dropped), .overflow(overflow), .done(done)
  );

  commit_trace_buffer #(.DATA_W(16), .REG_W(3), .DEPTH(8), .CNT_W(32), .TRACE_NOP(1'b0)) dutNoNop (
    .clk(clk), .rst(rst), .cm_valid(cmValid), .cm_pc(cmPc), .cm_reg_write(cmRegWrite),
    .cm_write_reg(cmWriteReg), .cm_write_data(cmWriteData), .cm_mem_read(cmMemRead),
    .cm_mem_write(cmMemWrite), .cm_mem_addr(cmMemAddr), .cm_mem_data(cmMemData),
    .cm_halt(cmHalt), .rec_valid(recValidN), .rec_ready(recReady), .rec_kind(recKindN),
    .rec_inum(recInumN), .rec_pc(recPcN), .rec_wdata(recWdataN), .rec_addr(recAddrN),
    .rec_mdata(recMdataN), .rec_reg(recRegN), .cycle_count(cycleCountN),
    .inst_count(instCountN), .dropped(droppedN), .overflow(overflowN), .done(doneN)
  );

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic commit(input logic [15:0] pc, input logic rw, input logic [2:0] wr,
                        input logic [15:0] wd, input logic mr, input logic mw,
                        input logic [15:0] ma, input logic [15:0] md, input logic h);
    cmValid = 1'b1; cmPc = pc; cmRegWrite = rw; cmWriteReg = wr; cmWriteData = wd;
    cmMemRead = mr; cmMemWrite = mw; cmMemAddr = ma; cmMemData = md; cmHalt = h;
    step();
    cmValid = 1'b0; cmPc = '0; cmRegWrite = 1'b0; cmWriteReg = '0; cmWriteData = '0;
    cmMemRead = 1'b0; cmMemWrite = 1'b0; cmMemAddr = '0; cmMemData = '0; cmHalt = 1'b0;
  endtask

  initial begin
    // Reset state and a single REG commit
    doReset();
    checkVal("rst_valid", 64'(recValid), 64'(0));
    checkVal("rst_cycle", 64'(cycleCount), 64'(0));
    checkVal("rst_inst", 64'(instCount), 64'(0));
    checkVal("rst_done", 64'(done), 64'(0));
    checkVal("rst_ovf", 64'(overflow), 64'(0));
    recReady = 1'b1;
    commit(16'h0002, 1'b1, 3'd3, 16'h00AB, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    checkVal("reg_valid", 64'(recValid), 64'(1));
    checkVal("reg_kind", 64'(recKind), 64'(1));
    checkVal("reg_inum", 64'(recInum), 64'(0));
    checkVal("reg_pc", 64'(recPc), 64'(16'h0002));
    checkVal("reg_reg", 64'(recReg), 64'(3));
    checkVal("reg_wdata", 64'(recWdata), 64'(16'h00AB));
    checkVal("reg_addr", 64'(recAddr), 64'(0));
    checkVal("reg_mdata", 64'(recMdata), 64'(0));
    checkVal("reg_inst", 64'(instCount), 64'(1));
    checkVal("reg_cycle", 64'(cycleCount), 64'(1));
    step();
    checkVal("reg_popped", 64'(recValid), 64'(0));

    // STU, LD and ST field forcing
    commit(16'h0010, 1'b1, 3'd5, 16'h1234, 1'b0, 1'b1, 16'h0020, 16'h5555, 1'b0);
    checkVal("stu_kind", 64'(recKind), 64'(4));
    checkVal("stu_inum", 64'(recInum), 64'(1));
    checkVal("stu_reg", 64'(recReg), 64'(5));
    checkVal("stu_wdata", 64'(recWdata), 64'(16'h1234));
    checkVal("stu_addr", 64'(recAddr), 64'(16'h0020));
    checkVal("stu_mdata", 64'(recMdata), 64'(16'h5555));
    step();
    commit(16'h0012, 1'b1, 3'd2, 16'h0077, 1'b1, 1'b0, 16'h0030, 16'h9999, 1'b0);
    checkVal("ld_kind", 64'(recKind), 64'(2));
    checkVal("ld_wdata", 64'(recWdata), 64'(16'h0077));
    checkVal("ld_addr", 64'(recAddr), 64'(16'h0030));
    checkVal("ld_mdata", 64'(recMdata), 64'(0));
    step();
    commit(16'h0014, 1'b0, 3'd6, 16'h1111, 1'b0, 1'b1, 16'h0040, 16'hBEEF, 1'b0);
    checkVal("st_kind", 64'(recKind), 64'(3));
    checkVal("st_reg", 64'(recReg), 64'(0));
    checkVal("st_wdata", 64'(recWdata), 64'(0));
    checkVal("st_mdata", 64'(recMdata), 64'(16'hBEEF));
    step();

    // Overflow: 10 commits into an 8-deep FIFO with no consumer
    doReset();
    recReady = 1'b0;
    for (int i = 0; i < 10; i++)
      commit(16'(16'h0100 + 2 * i), 1'b1, 3'(i), 16'(16'h0100 + i), 1'b0, 1'b0, '0, '0, 1'b0);
    checkVal("ovf_dropped", 64'(dropped), 64'(2));
    checkVal("ovf_flag", 64'(overflow), 64'(1));
    checkVal("ovf_inst", 64'(instCount), 64'(10));
    checkVal("ovf_head", 64'(recInum), 64'(0));

    // Full FIFO, pop and push in the same cycle
    recReady = 1'b1;
    commit(16'h0200, 1'b1, 3'd1, 16'h0AAA, 1'b0, 1'b0, '0, '0, 1'b0);
    checkVal("fullpp_dropped", 64'(dropped), 64'(2));
    checkVal("fullpp_inst", 64'(instCount), 64'(11));
    for (int k = 0; k < 8; k++) begin
      checkVal("drain_valid", 64'(recValid), 64'(1));
      checkVal("drain_inum", 64'(recInum), (k < 7) ? 64'(k + 1) : 64'(10));
      checkVal("drain_wdata", 64'(recWdata), (k < 7) ? 64'(16'h0101 + k) : 64'(16'h0AAA));
      step();
    end
    checkVal("drain_empty", 64'(recValid), 64'(0));

    // TRACE_NOP=0 instance: NOP, REG, NOP
    doReset();
    recReady = 1'b0;
    commit(16'h0050, 1'b0, 3'd4, 16'h7777, 1'b0, 1'b0, '0, '0, 1'b0);
    commit(16'h0052, 1'b1, 3'd1, 16'h0042, 1'b0, 1'b0, '0, '0, 1'b0);
    commit(16'h0054, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, '0, '0, 1'b0);
    checkVal("nonop_valid", 64'(recValidN), 64'(1));
    checkVal("nonop_inum", 64'(recInumN), 64'(1));
    checkVal("nonop_kind", 64'(recKindN), 64'(1));
    checkVal("nonop_inst", 64'(instCountN), 64'(3));
    checkVal("nop_kind", 64'(recKind), 64'(0));
    checkVal("nop_pc", 64'(recPc), 64'(16'h0050));
    checkVal("nop_wdata", 64'(recWdata), 64'(0));
    checkVal("nop_reg", 64'(recReg), 64'(0));
    recReady = 1'b1;
    step();
    checkVal("nonop_single", 64'(recValidN), 64'(0));
    checkVal("nop_next", 64'(recInum), 64'(1));

    // Halt with three records queued, then drain with rec_ready toggling
    doReset();
    recReady = 1'b0;
    for (int i = 0; i < 3; i++)
      commit(16'(16'h0100 + i), 1'b1, 3'(i + 1), 16'(16'h0200 + i), 1'b0, 1'b0, '0, '0, 1'b0);
    commit(16'h0060, 1'b1, 3'd7, 16'hFFFF, 1'b0, 1'b0, '0, '0, 1'b1);
    commit(16'h0070, 1'b1, 3'd2, 16'h0033, 1'b0, 1'b0, '0, '0, 1'b0);
    checkVal("halt_ignored", 64'(instCount), 64'(4));
    for (int k = 0; k < 5; k++) begin
      recReady = haltReady[k];
      checkVal("halt_valid", 64'(recValid), 64'(1));
      checkVal("halt_inum", 64'(recInum), 64'(haltExpInum[k]));
      checkVal("halt_done_early", 64'(done), 64'(0));
      if (k == 4) begin
        checkVal("halt_kind", 64'(recKind), 64'(5));
        checkVal("halt_pc", 64'(recPc), 64'(16'h0060));
        checkVal("halt_reg", 64'(recReg), 64'(0));
        checkVal("halt_wdata", 64'(recWdata), 64'(0));
      end
      step();
    end
    checkVal("halt_empty", 64'(recValid), 64'(0));
    checkVal("halt_done_not_yet", 64'(done), 64'(0));
    step();
    checkVal("halt_done", 64'(done), 64'(1));
    c0 = cycleCount;
    commit(16'h0080, 1'b1, 3'd1, 16'h0001, 1'b0, 1'b0, '0, '0, 1'b0);
    checkVal("done_inst", 64'(instCount), 64'(4));
    checkVal("done_novalid", 64'(recValid), 64'(0));
    checkVal("done_cycle", 64'(cycleCount), 64'(c0 + 32'd1));
    checkVal("done_sticky", 64'(done), 64'(1));

    // Reset in the middle of a drain
    doReset();
    recReady = 1'b0;
    commit(16'h0090, 1'b1, 3'd1, 16'h0011, 1'b0, 1'b0, '0, '0, 1'b0);
    commit(16'h0092, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, '0, '0, 1'b1);
    checkVal("middrain_valid", 64'(recValid), 64'(1));
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkVal("middrain_rst_valid", 64'(recValid), 64'(0));
    checkVal("middrain_rst_done", 64'(done), 64'(0));
    checkVal("middrain_rst_inst", 64'(instCount), 64'(0));
    checkVal("middrain_rst_cycle", 64'(cycleCount), 64'(0));
    commit(16'h00A0, 1'b1, 3'd6, 16'h0055, 1'b0, 1'b0, '0, '0, 1'b0);
    checkVal("middrain_run_valid", 64'(recValid), 64'(1));
    checkVal("middrain_run_inum", 64'(recInum), 64'(0));
    checkVal("middrain_run_inst", 64'(instCount), 64'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
